// File: rtl/axi_lite_bram_ctrl.sv
// axi_lite_bram_ctrl: AXI4-Lite slave bridging one CPU port to one single-port BRAM port.
// One transaction at a time through a single FSM; writes win over reads in IDLE.
// Optional build macro AXI_BRAM_ADDR_CHECK_EN: addresses >= MEM_BYTES get DECERR and no BRAM access.
module axi_lite_bram_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_BYTES  = 65536
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wrdata,
    input  logic [31:0]           bram_rddata
);
    typedef enum logic [2:0] {
        IDLE, WR_WAIT_W, WR_WAIT_A, WR_EXEC, WR_RESP, RD_EXEC, RD_CAPT, RD_RESP
    } state_t;

    state_t      state, state_nx;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        in_range;
    logic        unused;

`ifdef AXI_BRAM_ADDR_CHECK_EN
    assign in_range = addr < 32'(MEM_BYTES);
`else
    assign in_range = 1'b1;
`endif

    // Protection bits, the byte offset and (by default) the upper address bits carry no meaning here.
    assign unused      = &{1'b0, s_axi_awprot, s_axi_arprot, addr, 32'(MEM_BYTES)};
    assign bram_addr   = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign bram_wrdata = data;

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state plus state-decoded readys, valids and BRAM strobes; AR only seen when no write is offered.
    always_comb begin
        state_nx      = state;
        s_axi_awready = reset_n && (state == IDLE || state == WR_WAIT_A);
        s_axi_wready  = reset_n && (state == IDLE || state == WR_WAIT_W);
        s_axi_arready = reset_n && state == IDLE && !s_axi_awvalid && !s_axi_wvalid;
        s_axi_bvalid  = state == WR_RESP;
        s_axi_rvalid  = state == RD_RESP;
        bram_en       = in_range && ((state == WR_EXEC && strb != 4'b0) || state == RD_EXEC);
        bram_we       = (state == WR_EXEC && in_range) ? strb : 4'b0;
        case (state)
            IDLE:      state_nx = (s_axi_awvalid && s_axi_wvalid) ? WR_EXEC   :
                                  s_axi_awvalid                   ? WR_WAIT_W :
                                  s_axi_wvalid                    ? WR_WAIT_A :
                                  s_axi_arvalid                   ? RD_EXEC   : IDLE;
            WR_WAIT_W: state_nx = s_axi_wvalid  ? WR_EXEC : WR_WAIT_W;
            WR_WAIT_A: state_nx = s_axi_awvalid ? WR_EXEC : WR_WAIT_A;
            WR_EXEC:   state_nx = WR_RESP;
            WR_RESP:   state_nx = s_axi_bready ? IDLE : WR_RESP;
            RD_EXEC:   state_nx = RD_CAPT;
            RD_CAPT:   state_nx = RD_RESP;
            RD_RESP:   state_nx = s_axi_rready ? IDLE : RD_RESP;
            default:   state_nx = IDLE;
        endcase
    end

    // Latch request fields on their handshakes and register responses so AXI outputs never glitch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr        <= '0;
            data        <= '0;
            strb        <= '0;
            s_axi_bresp <= 2'b00;
            s_axi_rresp <= 2'b00;
            s_axi_rdata <= '0;
        end else begin
            if (s_axi_awvalid && s_axi_awready) addr <= s_axi_awaddr;
            if (s_axi_arvalid && s_axi_arready) addr <= s_axi_araddr;
            if (s_axi_wvalid && s_axi_wready) begin
                data <= s_axi_wdata;
                strb <= s_axi_wstrb;
            end
            if (state == WR_EXEC) s_axi_bresp <= in_range ? 2'b00 : 2'b11;
            if (state == RD_CAPT) begin
                s_axi_rdata <= in_range ? bram_rddata : 32'h0;
                s_axi_rresp <= in_range ? 2'b00 : 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// tb_axi_lite_bram_ctrl: directed vector table, corner-case sequences and random traffic against a memory model.
module tb_axi_lite_bram_ctrl;
    localparam int MEM = 32'h8000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic        s_axi_bready = 1'b0, s_axi_rready = 1'b0;
    logic        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [15:0] bram_addr;
    logic [31:0] bram_wrdata;
    logic [31:0] bram_rddata = '0;

    axi_lite_bram_ctrl #(.ADDR_WIDTH(16), .MEM_BYTES(MEM)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0, n_err = 0;
    int en_cnt = 0, en_cyc = -1;
    logic [3:0]  en_we;
    logic [15:0] en_addr;
    logic [31:0] en_wd;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM port activity log
    always @(negedge clk) if (bram_en) begin
        en_cnt  <= en_cnt + 1;
        en_cyc  <= cyc;
        en_we   <= bram_we;
        en_addr <= bram_addr;
        en_wd   <= bram_wrdata;
    end

    // Single-port BRAM, one cycle read latency
    logic [31:0] mem [0:16383];
    initial for (int i = 0; i < 16384; i++) mem[i] = '0;
    always @(posedge clk) if (bram_en) begin
        if (bram_we == 4'b0) bram_rddata <= mem[bram_addr[15:2]];
        for (int i = 0; i < 4; i++) if (bram_we[i]) mem[bram_addr[15:2]][8*i +: 8] <= bram_wrdata[8*i +: 8];
    end

    // Reference memory: word index -> contents, absent words read as zero
    logic [31:0] ref_mem [int];

    function automatic bit in_rng(input logic [31:0] a);
`ifdef AXI_BRAM_ADDR_CHECK_EN
        return a < MEM;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a % 32'h10000) / 4;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (!in_rng(a) || !ref_mem.exists(widx(a))) return '0;
        return ref_mem[widx(a)];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Offer the selected valids until each is accepted; n = cycle of the last acceptance.
    task automatic hs(input bit aw, input bit w, input bit ar, output int n);
        int t = 0;
        bit ga, gw, gr;
        n = cyc;
        s_axi_awvalid = aw; s_axi_wvalid = w; s_axi_arvalid = ar;
        #1;
        while ((s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) && t < 20) begin
            n  = cyc;
            ga = s_axi_awvalid && s_axi_awready;
            gw = s_axi_wvalid && s_axi_wready;
            gr = s_axi_arvalid && s_axi_arready;
            @(negedge clk);
            if (ga) s_axi_awvalid = 1'b0;
            if (gw) s_axi_wvalid = 1'b0;
            if (gr) s_axi_arvalid = 1'b0;
            #1;
            t++;
        end
        chk("hs_timeout", 32'(t >= 20), 0);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_b(input int n, input int hold, input logic [1:0] exp, input string nm);
        int t = 0;
        logic [1:0] r;
        while (!s_axi_bvalid && t < 20) begin @(negedge clk); #1; t++; end
        chk({nm, " b_lat"}, cyc, n + 2);
        chk({nm, " bresp"}, s_axi_bresp, exp);
        r = s_axi_bresp;
        repeat (hold) begin
            chk({nm, " b_rdy"}, {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
            @(negedge clk); #1;
            chk({nm, " b_hold"}, {s_axi_bvalid, s_axi_bresp}, {1'b1, r});
        end
        s_axi_bready = 1'b1;
        @(negedge clk); s_axi_bready = 1'b0; #1;
        chk({nm, " b_done"}, s_axi_bvalid, 0);
    endtask

    task automatic wait_r(input int n, input int hold, input logic [31:0] exp_d, input logic [1:0] exp, input string nm);
        int t = 0;
        logic [1:0]  r;
        logic [31:0] d;
        while (!s_axi_rvalid && t < 20) begin @(negedge clk); #1; t++; end
        chk({nm, " r_lat"}, cyc, n + 3);
        chk({nm, " rdata"}, s_axi_rdata, exp_d);
        chk({nm, " rresp"}, s_axi_rresp, exp);
        r = s_axi_rresp;
        d = s_axi_rdata;
        repeat (hold) begin
            chk({nm, " r_rdy"}, {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
            @(negedge clk); #1;
            chk({nm, " r_hold"}, {s_axi_rvalid, s_axi_rresp}, {1'b1, r});
            chk({nm, " rdata_hold"}, s_axi_rdata, d);
        end
        s_axi_rready = 1'b1;
        @(negedge clk); s_axi_rready = 1'b0; #1;
        chk({nm, " r_done"}, s_axi_rvalid, 0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int hold, input logic [1:0] resp, input string nm);
        int n, e0;
        bit acc;
        logic [31:0] w;
        acc = in_rng(a) && s != 4'b0;
        e0 = en_cnt;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        if (lead > 0) begin
            hs(0, 1, 0, n);
            repeat (lead - 1) begin @(negedge clk); #1; end
            hs(1, 0, 0, n);
        end else hs(1, 1, 0, n);
        wait_b(n, hold, resp, nm);
        chk({nm, " en_cnt"}, en_cnt - e0, 32'(acc));
        if (acc) begin
            chk({nm, " en_lat"}, en_cyc, n + 1);
            chk({nm, " we"}, en_we, s);
            chk({nm, " addr"}, en_addr, (a % 32'h10000) & ~32'h3);
            chk({nm, " wdata"}, en_wd, d);
        end
        if (in_rng(a)) begin
            w = ref_rd(a);
            for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            ref_mem[widx(a)] = w;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, input logic [31:0] exp_d,
                           input logic [1:0] resp, input string nm);
        int n, e0;
        e0 = en_cnt;
        s_axi_araddr = a;
        hs(0, 0, 1, n);
        wait_r(n, hold, exp_d, resp, nm);
        chk({nm, " en_cnt"}, en_cnt - e0, 32'(in_rng(a)));
        if (in_rng(a)) begin
            chk({nm, " en_lat"}, en_cyc, n + 1);
            chk({nm, " we"}, en_we, 0);
            chk({nm, " addr"}, en_addr, (a % 32'h10000) & ~32'h3);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          lead;
        int          hold;
        logic [1:0]  resp;
    } vec_t;

    function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                input int lead, input int hold, input logic [1:0] resp);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.s = s; v.lead = lead; v.hold = hold; v.resp = resp;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        int          n, t;
        logic [31:0] a;

        // For reads, d is the expected read data
        tbl.push_back(mk(1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 0, 2'b00));
        tbl.push_back(mk(0, 32'h10,   32'hDEADBEEF, 4'h0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 32'h13,   32'h000000AA, 4'h1, 2, 0, 2'b00));
        tbl.push_back(mk(0, 32'h10,   32'hDEADBEAA, 4'h0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 32'h20,   32'h12345678, 4'h0, 0, 0, 2'b00));
        tbl.push_back(mk(0, 32'h20,   32'h00000000, 4'h0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 32'h30,   32'h11223344, 4'hA, 1, 2, 2'b00));
        tbl.push_back(mk(0, 32'h31,   32'h11003300, 4'h0, 0, 1, 2'b00));
        tbl.push_back(mk(1, 32'h7FFC, 32'h0BADCAFE, 4'hF, 0, 5, 2'b00));
        tbl.push_back(mk(0, 32'h7FFC, 32'h0BADCAFE, 4'h0, 0, 5, 2'b00));
`ifdef AXI_BRAM_ADDR_CHECK_EN
        tbl.push_back(mk(0, 32'h8000, 32'h00000000, 4'h0, 0, 0, 2'b11));
        tbl.push_back(mk(1, 32'h8010, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b11));
        tbl.push_back(mk(0, 32'h10,   32'hDEADBEAA, 4'h0, 0, 0, 2'b00));
`else
        tbl.push_back(mk(1, 32'h10024, 32'hCAFEF00D, 4'hF, 0, 0, 2'b00));
        tbl.push_back(mk(0, 32'h24,    32'hCAFEF00D, 4'h0, 0, 0, 2'b00));
        tbl.push_back(mk(0, 32'hFFFE,  32'h00000000, 4'h0, 0, 0, 2'b00));
`endif

        // Power-on reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 0);
        chk("rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
        chk("rst_bram", {bram_en, bram_we}, 0);
        chk("rst_resp", {s_axi_bresp, s_axi_rresp}, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        foreach (tbl[i]) begin
            if (tbl[i].wr) do_write(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].lead, tbl[i].hold, tbl[i].resp, $sformatf("vec%0d", i));
            else           do_read(tbl[i].a, tbl[i].hold, tbl[i].d, tbl[i].resp, $sformatf("vec%0d", i));
        end

        // Reset while a read response is pending, then an immediate read after release
        s_axi_araddr = 32'h10;
        hs(0, 0, 1, n);
        t = 0;
        while (!s_axi_rvalid && t < 20) begin @(negedge clk); #1; t++; end
        chk("rsthold_pre_rvalid", s_axi_rvalid, 1);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("rsthold_rvalid", s_axi_rvalid, 0);
            chk("rsthold_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
            chk("rsthold_bram_en", bram_en, 0);
            chk("rsthold_rdata", s_axi_rdata, 0);
        end
        reset_n = 1'b1;
        s_axi_arvalid = 1'b1;
        #1;
        chk("rst_release_arready", s_axi_arready, 1);
        n = cyc;
        @(negedge clk); s_axi_arvalid = 1'b0; #1;
        wait_r(n, 0, ref_rd(32'h10), 2'b00, "rst_rd");

        // AW, W and AR together: write first, AR held off until the write response completes
        s_axi_awaddr = 32'h40; s_axi_wdata = 32'h5A5A1234; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h40;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        #1;
        chk("col_arready_idle", s_axi_arready, 0);
        chk("col_wr_readys", {s_axi_awready, s_axi_wready}, 2'b11);
        n = cyc;
        @(negedge clk); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; #1;
        chk("col_arready_exec", s_axi_arready, 0);
        wait_b(n, 2, 2'b00, "col_wr");
        ref_mem[widx(32'h40)] = 32'h5A5A1234;
        chk("col_arready_after", s_axi_arready, 1);
        n = cyc;
        @(negedge clk); s_axi_arvalid = 1'b0; #1;
        wait_r(n, 0, ref_rd(32'h40), 2'b00, "col_rd");

        // Random traffic, including aliased and out-of-range addresses
        for (int i = 0; i < 40; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3))
              + ($urandom_range(0, 1) == 1 ? 32'h8000 : 32'h0)
              + ($urandom_range(0, 3) == 0 ? 32'h10000 : 32'h0);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                         in_rng(a) ? 2'b00 : 2'b11, "rnd_wr");
            else
                do_read(a, $urandom_range(0, 2), ref_rd(a), in_rng(a) ? 2'b00 : 2'b11, "rnd_rd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
